// File: rtl/scheduler_pkg.sv
// Shared constants for the context-switch scheduler: opcodes, switch causes,
// FSM encoding and CXC_REGISTER field positions.
package scheduler_pkg;

  localparam logic [5:0] OPC_HLT   = 6'b011100;
  localparam logic [5:0] OPC_PREIO = 6'b011110;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_QUANTUM = 2'd1,
    CAUSE_PREIO   = 2'd2,
    CAUSE_HLT     = 2'd3
  } cause_e;

  typedef enum logic {
    ST_COUNTING = 1'b0,
    ST_REQUEST  = 1'b1
  } state_e;

  localparam int CXC_CAUSE_LSB = 0;
  localparam int CXC_CAUSE_W   = 2;
  localparam int CXC_PID_LSB   = 8;
  localparam int CXC_NONE_BIT  = 16;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set mask bit after base_i (wrapping), base_i itself
// considered last. pid_o falls back to base_i when nothing is ready.
module rr_picker #(
  parameter int NUM_PROCESSES = 8,
  parameter int PID_WIDTH     = 3
) (
  input  logic [NUM_PROCESSES-1:0] mask_i,
  input  logic [PID_WIDTH-1:0]     base_i,
  output logic [PID_WIDTH-1:0]     pid_o,
  output logic                     valid_o
);

  logic [PID_WIDTH-1:0] cand_s [NUM_PROCESSES];

  // Candidate i is base+i+1; the last one wraps back onto base itself.
  for (genvar g = 0; g < NUM_PROCESSES; g++) begin : g_cand
    assign cand_s[g] = base_i + PID_WIDTH'(g + 1);
  end

  // Scan from farthest to nearest so the nearest ready candidate wins.
  always_comb begin
    pid_o   = base_i;
    valid_o = 1'b0;
    for (int i = NUM_PROCESSES - 1; i >= 0; i--) begin
      pid_o   = mask_i[cand_s[i]] ? cand_s[i] : pid_o;
      valid_o = valid_o | mask_i[cand_s[i]];
    end
  end

endmodule

// File: rtl/context_switch_scheduler.sv
// Quantum/HLT/PREIO driven context-switch requester with a ready mask and a
// handshake (LOAD_CXC / CXC_ACK) towards the OS.
module context_switch_scheduler
  import scheduler_pkg::*;
#(
  parameter int OPCODE_WIDTH       = 6,
  parameter int INSTMEM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH         = 32,
  parameter int NUM_PROCESSES      = 8,
  parameter int PID_WIDTH          = 3,
  parameter int COUNTER_WIDTH      = 8,
  parameter int DEFAULT_QUANTUM    = 15,
  parameter int OS_MENU_ADDRESS    = 512
) (
  input  logic                          WCLOCK,
  input  logic                          RESET_N,
  input  logic                          MUX_SYSTEM_INSTRUCTION,
  input  logic [OPCODE_WIDTH-1:0]       OPCODE,
  input  logic [INSTMEM_ADDR_WIDTH-1:0] PC,
  input  logic                          QUANTUM_WE,
  input  logic [COUNTER_WIDTH-1:0]      QUANTUM_IN,
  input  logic                          IO_DONE,
  input  logic [PID_WIDTH-1:0]          IO_DONE_PID,
  input  logic                          CXC_ACK,
  output logic [DATA_WIDTH-1:0]         CXC_REGISTER,
  output logic                          LOAD_CXC,
  output logic [PID_WIDTH-1:0]          CURRENT_PID,
  output logic [NUM_PROCESSES-1:0]      READY_MASK
);

  state_e                     state_q;
  logic                       load_q;
  logic [COUNTER_WIDTH-1:0]   counter_q;
  logic [COUNTER_WIDTH-1:0]   quantum_q;
  logic [COUNTER_WIDTH-1:0]   quantum_d;
  logic [PID_WIDTH-1:0]       current_pid_q;
  logic [NUM_PROCESSES-1:0]   ready_mask_q;
  logic [NUM_PROCESSES-1:0]   ready_mask_d;
  logic [DATA_WIDTH-1:0]      cxc_q;
  logic [DATA_WIDTH-1:0]      cxc_d;

  logic                       user_scope_s;
  logic                       req_s;
  logic                       clear_s;
  cause_e                     cause_s;
  logic [PID_WIDTH-1:0]       pick_pid_s;
  logic                       pick_valid_s;

  assign user_scope_s = MUX_SYSTEM_INSTRUCTION &&
                        (PC < INSTMEM_ADDR_WIDTH'(OS_MENU_ADDRESS));

  // Switch decision for this edge: HLT beats PREIO beats quantum expiry.
  always_comb begin
    req_s   = 1'b0;
    clear_s = 1'b0;
    cause_s = CAUSE_NONE;
    if ((state_q == ST_COUNTING) && user_scope_s) begin
      if (OPCODE == OPCODE_WIDTH'(OPC_HLT)) begin
        req_s   = 1'b1;
        clear_s = 1'b1;
        cause_s = CAUSE_HLT;
      end else if (OPCODE == OPCODE_WIDTH'(OPC_PREIO)) begin
        req_s   = 1'b1;
        clear_s = 1'b1;
        cause_s = CAUSE_PREIO;
      end else if (counter_q >= quantum_q) begin
        req_s   = 1'b1;
        cause_s = CAUSE_QUANTUM;
      end else begin
        req_s   = 1'b0;
      end
    end else begin
      req_s = 1'b0;
    end
  end

  // Ready-mask update; an I/O completion is applied after the clear so it wins.
  always_comb begin
    ready_mask_d = ready_mask_q;
    if (clear_s) begin
      ready_mask_d[current_pid_q] = 1'b0;
    end else begin
      ready_mask_d = ready_mask_q;
    end
    if (IO_DONE) begin
      ready_mask_d[IO_DONE_PID] = 1'b1;
    end else begin
      ready_mask_d = ready_mask_d;
    end
  end

  // A zero quantum would request every cycle with no progress, so clamp to 1.
  always_comb begin
    quantum_d = quantum_q;
    if (QUANTUM_WE) begin
      quantum_d = (QUANTUM_IN == {COUNTER_WIDTH{1'b0}}) ? COUNTER_WIDTH'(1) : QUANTUM_IN;
    end else begin
      quantum_d = quantum_q;
    end
  end

  rr_picker #(
    .NUM_PROCESSES (NUM_PROCESSES),
    .PID_WIDTH     (PID_WIDTH)
  ) u_rr_picker (
    .mask_i  (ready_mask_d),
    .base_i  (current_pid_q),
    .pid_o   (pick_pid_s),
    .valid_o (pick_valid_s)
  );

  // Value captured into CXC_REGISTER on entry to REQUEST.
  always_comb begin
    cxc_d                                  = {DATA_WIDTH{1'b0}};
    cxc_d[CXC_CAUSE_LSB +: CXC_CAUSE_W]    = cause_s;
    cxc_d[CXC_PID_LSB +: PID_WIDTH]        = pick_pid_s;
    cxc_d[CXC_NONE_BIT]                    = ~pick_valid_s;
  end

  // Scheduler FSM with all architectural state and registered outputs.
  always_ff @(posedge WCLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_COUNTING;
      load_q        <= 1'b0;
      counter_q     <= {COUNTER_WIDTH{1'b0}};
      quantum_q     <= COUNTER_WIDTH'(DEFAULT_QUANTUM);
      current_pid_q <= {PID_WIDTH{1'b0}};
      ready_mask_q  <= {NUM_PROCESSES{1'b1}};
      cxc_q         <= {DATA_WIDTH{1'b0}};
    end else begin
      ready_mask_q <= ready_mask_d;
      quantum_q    <= quantum_d;
      case (state_q)
        ST_COUNTING: begin
          if (req_s) begin
            state_q <= ST_REQUEST;
            load_q  <= 1'b1;
            cxc_q   <= cxc_d;
          end else if (user_scope_s) begin
            counter_q <= counter_q + COUNTER_WIDTH'(1);
          end else begin
            counter_q <= counter_q;
          end
        end
        ST_REQUEST: begin
          if (CXC_ACK) begin
            state_q       <= ST_COUNTING;
            load_q        <= 1'b0;
            counter_q     <= {COUNTER_WIDTH{1'b0}};
            current_pid_q <= cxc_q[CXC_PID_LSB +: PID_WIDTH];
          end else begin
            state_q <= ST_REQUEST;
            load_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_COUNTING;
          load_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CXC_REGISTER = cxc_q;
  assign LOAD_CXC     = load_q;
  assign CURRENT_PID  = current_pid_q;
  assign READY_MASK   = ready_mask_q;

endmodule
